param_restoring_divider: RTL and testbench

//  Multi-cycle restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient, N-bit remainder.

---
 rtl/param_restoring_divider.sv | 91 +++++++++
 tb/tb_param_restoring_divider.sv | 129 ++++++++++++
 2 files changed

// File: rtl/param_restoring_divider.sv
// param_restoring_divider: multi-cycle restoring divider, 2N/N bits, unsigned or signed, with held results and flags
module param_restoring_divider #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [2*N-1:0] w,
  input  logic [N-1:0]   d,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem,
  output logic           busy,
  output logic           done,
  output logic           ov,
  output logic           divbyzero
);
  localparam int CW = $clog2(N+1);
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CHECK, CALC, FIX} state_t;
  state_t state, nxt;
  logic [2*N-1:0] w_l, w_abs;
  logic [N-1:0] d_l, d_abs, lo, da, q, q_s, r_s;
  logic [N:0] pr, sh;
  logic [CW-1:0] cnt;
  logic sm, ge, neg, q_ov, bad;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next state; operand errors bail out of CHECK straight back to IDLE
  always_comb begin
    nxt = state == IDLE  ? (start ? CHECK : IDLE) :
          state == CHECK ? (bad ? IDLE : CALC) :
          state == CALC  ? (cnt == CW'(1) ? FIX : CALC) : IDLE;
  end
  // magnitudes, trial subtraction and signed fix-up
  always_comb begin
    busy  = state != IDLE;
    w_abs = (sm && w_l[2*N-1]) ? -w_l : w_l;
    d_abs = (sm && d_l[N-1]) ? -d_l : d_l;
    bad   = d_l == '0 || w_abs[2*N-1:N] >= d_abs;
    sh    = {pr[N-1:0], lo[N-1]};
    ge    = sh >= {1'b0, da};
    neg   = sm && (w_l[2*N-1] ^ d_l[N-1]);
    q_s   = neg ? -q : q;
    r_s   = (sm && w_l[2*N-1]) ? -pr[N-1:0] : pr[N-1:0];
    q_ov  = sm && (neg ? q > HALF : q >= HALF);
  end
  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {w_l, d_l, sm, lo, da, q, pr, cnt} <= '0;
      {quo, rem, done, ov, divbyzero} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_l <= w;
          d_l <= d;
          sm <= signed_mode;
          ov <= 1'b0;
          divbyzero <= 1'b0;
        end
        CHECK: if (bad) begin
          divbyzero <= d_l == '0;
          ov <= d_l != '0;
          quo <= '0;
          rem <= '0;
          done <= 1'b1;
        end else begin
          pr <= {1'b0, w_abs[2*N-1:N]};
          lo <= w_abs[N-1:0];
          da <= d_abs;
          cnt <= CW'(N);
        end
        CALC: begin
          pr <= ge ? sh - {1'b0, da} : sh;
          q <= {q[N-2:0], ge};
          lo <= lo << 1;
          cnt <= cnt - 1'b1;
        end
        default: begin
          ov <= q_ov;
          quo <= q_ov ? '0 : q_s;
          rem <= q_ov ? '0 : r_s;
          done <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_param_restoring_divider.sv
// tb_param_restoring_divider: random and directed checks against an arithmetic reference model
module tb_param_restoring_divider;
  localparam int N = 5;
  logic clk = 0, rst = 0, start = 0, signed_mode = 0;
  logic [2*N-1:0] w = '0;
  logic [N-1:0] d = '0, quo, rem;
  logic busy, done, ov, divbyzero;
  int checks = 0, errors = 0;

  param_restoring_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .w(w), .d(d),
    .quo(quo), .rem(rem), .busy(busy), .done(done), .ov(ov), .divbyzero(divbyzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // plain integer division on the operands as numbers
  function automatic void model(input logic s, input logic [2*N-1:0] wv, input logic [N-1:0] dv,
                                output int eq, output int er, output int eov, output int edz,
                                output int elat);
    int wi, di, wa, da, qi, ri;
    wi = s ? int'($signed(wv)) : int'(wv);
    di = s ? int'($signed(dv)) : int'(dv);
    wa = wi < 0 ? -wi : wi;
    da = di < 0 ? -di : di;
    eq = 0; er = 0; eov = 0; edz = 0; elat = N + 2;
    if (di == 0) begin
      edz = 1; elat = 1;
    end else if (wa / da >= (1 << N)) begin
      eov = 1; elat = 1;
    end else begin
      qi = wi / di;
      ri = wi % di;
      if (s && (qi > (1 << (N-1)) - 1 || qi < -(1 << (N-1)))) eov = 1;
      else begin
        eq = qi & ((1 << N) - 1);
        er = ri & ((1 << N) - 1);
      end
    end
  endfunction

  task automatic do_op(input logic s, input logic [2*N-1:0] wv, input logic [N-1:0] dv,
                       input bit noise, input bit gap);
    int eq, er, eov, edz, elat, n;
    model(s, wv, dv, eq, er, eov, edz, elat);
    start = 1; signed_mode = s; w = wv; d = dv;
    @(posedge clk); #1;
    chk("busy_accept", int'(busy), 1);
    chk("flags_clear", int'({ov, divbyzero}), 0);
    start = 0; w = 2*N'($urandom); d = N'($urandom); signed_mode = 1'($urandom);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      chk("busy_run", int'(busy), 1);
      start = noise ? 1'($urandom) : 1'b0;
      w = 2*N'($urandom); d = N'($urandom);
    end
    start = 0;
    chk("latency", n, elat);
    chk("busy_done", int'(busy), 0);
    chk("quo", int'(quo), eq);
    chk("rem", int'(rem), er);
    chk("ov", int'(ov), eov);
    chk("divbyzero", int'(divbyzero), edz);
    if (gap) begin
      @(posedge clk); #1;
      chk("done_pulse", int'(done), 0);
      chk("quo_hold", int'(quo), eq);
      chk("ov_hold", int'(ov), eov);
    end
  endtask

  initial begin
    logic [6:0] sm7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", int'({quo, rem, busy, done, ov, divbyzero}), 0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);
    do_op(0, 10'd75, 5'd11, 0, 1);
    chk("t1_quo", int'(quo), 6);
    do_op(0, 10'd213, 5'd25, 0, 1);
    do_op(0, 10'd1013, 5'd25, 0, 1);
    do_op(0, 10'd91, 5'd0, 0, 1);
    do_op(1, 10'd91, 5'd0, 0, 0);
    do_op(0, 10'd91, 5'd15, 0, 1);
    do_op(1, -10'sd75, 5'd11, 0, 1);
    chk("t4_quo", int'(quo), 5'b11010);
    chk("t4_rem", int'(rem), 5'b10111);
    do_op(1, -10'sd160, 5'd10, 0, 1);
    chk("t4_quo_min", int'(quo), 5'b10000);
    do_op(1, 10'd160, 5'd10, 0, 1);
    do_op(1, 10'd75, -5'sd16, 1, 1);
    do_op(0, 10'd500, 5'd31, 1, 0);
    do_op(0, 10'd1023, 5'd31, 1, 1);
    start = 1; signed_mode = 0; w = 10'd75; d = 5'd11;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_async", int'({quo, rem, busy, done, ov, divbyzero}), 0);
    @(posedge clk); #1;
    chk("rst_hold", int'({quo, rem, busy, done, ov, divbyzero}), 0);
    rst = 1;
    do_op(0, 10'd75, 5'd11, 0, 1);
    for (int i = 0; i < 80; i++) begin
      logic s;
      logic [2*N-1:0] wv;
      s = 1'($urandom);
      sm7 = 7'($urandom);
      wv = ($urandom % 2) ? 2*N'($urandom) : (s ? 10'($signed(sm7)) : 10'(sm7));
      do_op(s, wv, N'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
